sindoku_board: RTL
==================

SINDOKU_BOARD -- requirements
Module: sindoku_board

Interface
REQ-001 Parameter BOX, default 3: sub-box edge; legal 2..4; GRID = BOX*BOX cells per row/column.
REQ-002 Parameter CW, default 4: cell value width; SHALL satisfy 2^CW > GRID; RW = $clog2(GRID) is the row/column index width.
REQ-003 Ports, one per line: name direction width meaning.
  Clk  in  1  single clock, rising edge.
  Reset_n  in  1  asynchronous, active-low reset.
  LoadStart  in  1  begin puzzle load (I state only).
  LdValid  in  1  one cell beat, row-major order.
  LdGiven  in  CW  given value of the beat's cell (0 = blank).
  LdSolu  in  CW  solution value of the beat's cell.
  R, L, U, D  in  1 each  single-cycle cursor move pulses.
  C  in  1  commit UserIn to the cursor cell.
  Clr  in  1  clear the cursor cell.
  UserIn  in  CW  player value.
  CheckSolu  in  1  request solution check.
  Ack  in  1  leave CORRECT/INCORRECT.
  DispRow, DispCol  in  RW each  display read address.
  DispVal  out  CW  cell value at the display address.
  DispGiven  out  1  cell at the display address is a given.
  CurRow, CurCol  out  RW each  cursor position.
  ErrCount  out  $clog2(GRID*GRID+1)  mismatches found by the last check.
  FirstErrRow, FirstErrCol  out  RW each  first mismatching cell of the last check, row-major.
  q_I, q_Load, q_Solve, q_Check, q_Correct, q_Incorrect  out  1 each  one-hot state.

Function
REQ-004 States I, LOAD, SOLVE, CHECK, CORRECT, INCORRECT; exactly one q_* SHALL be high at all times.
REQ-005 I: LoadStart -> LOAD, load index 0; all other inputs ignored.
REQ-006 LOAD: each LdValid cycle writes solu[idx] = LdSolu, puzzle[idx] = LdGiven, given[idx] = (LdGiven != 0), then idx+1; the beat at idx = GRID*GRID-1 SHALL move to SOLVE on the next edge with cursor (0,0); cycles without LdValid hold.
REQ-007 SOLVE priority per cycle: CheckSolu > Clr > C; CheckSolu -> CHECK, and moves, Clr and C that cycle are ignored.
REQ-008 Clr writes 0, and C writes UserIn, to the cell at the pre-move cursor only if that cell is not given; C with UserIn = 0 or UserIn > GRID is ignored.
REQ-009 Moves wrap: R at column GRID-1 -> 0, L at 0 -> GRID-1, D at row GRID-1 -> 0, U at 0 -> GRID-1; R with L together leaves the column unchanged, and U with D together leaves the row unchanged.
REQ-010 CHECK: scans exactly one cell per cycle, row-major, for GRID*GRID cycles; a cell mismatches when puzzle != solu (blank counts); ErrCount and FirstErr* clear on entry and update during the scan.
REQ-011 After the last cell: ErrCount == 0 -> CORRECT, else INCORRECT; CHECK SHALL last exactly GRID*GRID cycles.
REQ-012 INCORRECT + Ack -> SOLVE with cursor and board kept. CORRECT + Ack -> I with the board kept. Both states hold without Ack and ignore all other inputs.
REQ-013 ErrCount and FirstErr* SHALL hold their last values outside CHECK.
REQ-014 DispVal and DispGiven are combinational from the addressed cell; an address >= GRID SHALL return 0.
REQ-015 The given flags SHALL make given cells immutable in SOLVE under every input combination.

Reset
REQ-016 Reset_n low SHALL force state I, cursor (0,0), load index 0, every puzzle, solu and given entry 0, ErrCount 0, FirstErr* 0, HintCount 0 -- asynchronously, including mid-LOAD or mid-CHECK.
REQ-017 The first edge after Reset_n rises SHALL behave as I.

Configuration
REQ-018 With SINDOKU_HINT_EN defined:
  - port Hint (in, 1) and port HintCount (out, 4) exist.
  - In SOLVE, Hint writes solu to the cursor cell if that cell is not given, and HintCount increments, saturating at 15.
  - Hint priority sits between Clr and C.
  - A check passed with HintCount != 0 still reaches CORRECT.
REQ-019 Without SINDOKU_HINT_EN, neither Hint nor HintCount exists and behaviour is otherwise identical.

Verification
REQ-020 BOX=3: load 81 beats, the last with a 3-cycle LdValid gap -> q_Solve rises the edge after beat 81; CurRow=CurCol=0.
REQ-021 Cursor at (0,8), pulse R -> (0,0). At (0,0), pulse U -> (8,0). R+L together at (4,4) -> (4,4).
REQ-022 Given 5 at (0,1): C with UserIn=7 -> DispVal stays 5. Blank (0,0): C UserIn=10 -> 0; C UserIn=2 -> 2; then Clr+C together -> 0.
REQ-023 Board with (1,2) and (7,7) wrong, CheckSolu -> q_Check high 81 cycles, then q_Incorrect, ErrCount=2, FirstErr=(1,2); Ack -> q_Solve.
REQ-024 Fully correct board, CheckSolu -> q_Correct after 81 cycles, ErrCount=0; Ack -> q_I. Reset_n pulsed at scan cycle 40 -> q_I, ErrCount=0, all DispVal 0.
REQ-025 With SINDOKU_HINT_EN: 16 Hint pulses on blank cells -> cells filled from solu, HintCount=15.

Source files
------------

// File: rtl/sindoku_board.sv
// sindoku_board: sudoku play board. Loads puzzle + solution cell by cell,
// lets the player move a cursor and edit non-given cells, then scans the board
// against the solution one cell per cycle.
// Optional feature macro: SINDOKU_HINT_EN (adds Hint input and HintCount output).
// Load handshake: LdValid beats are always accepted while in LOAD (no ready,
// no back-pressure); each beat fills the next cell in row-major order.
module sindoku_board #(
  parameter int BOX = 3,
  parameter int CW  = 4,
  localparam int GRID = BOX * BOX,
  localparam int RW   = $clog2(GRID),
  localparam int NC   = GRID * GRID,
  localparam int IW   = $clog2(NC),
  localparam int EW   = $clog2(NC + 1)
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          LoadStart,
  input  logic          LdValid,
  input  logic [CW-1:0] LdGiven,
  input  logic [CW-1:0] LdSolu,
  input  logic          R,
  input  logic          L,
  input  logic          U,
  input  logic          D,
  input  logic          C,
  input  logic          Clr,
  input  logic [CW-1:0] UserIn,
  input  logic          CheckSolu,
  input  logic          Ack,
`ifdef SINDOKU_HINT_EN
  input  logic          Hint,
  output logic [3:0]    HintCount,
`endif
  input  logic [RW-1:0] DispRow,
  input  logic [RW-1:0] DispCol,
  output logic [CW-1:0] DispVal,
  output logic          DispGiven,
  output logic [RW-1:0] CurRow,
  output logic [RW-1:0] CurCol,
  output logic [EW-1:0] ErrCount,
  output logic [RW-1:0] FirstErrRow,
  output logic [RW-1:0] FirstErrCol,
  output logic          q_I,
  output logic          q_Load,
  output logic          q_Solve,
  output logic          q_Check,
  output logic          q_Correct,
  output logic          q_Incorrect
);

  typedef enum logic [2:0] {S_I, S_LOAD, S_SOLVE, S_CHECK, S_CORRECT, S_INCORRECT} state_t;
  state_t state, state_nxt;

  logic [CW-1:0] puzzle [NC];
  logic [CW-1:0] solu   [NC];
  logic [NC-1:0] given;
  logic [IW-1:0] ld_idx;
  logic [RW-1:0] cur_row, cur_col, chk_row, chk_col;
  logic [RW-1:0] mv_row, mv_col;
  logic [EW-1:0] err_cnt;
  logic [RW-1:0] ferr_row, ferr_col;
  logic [IW-1:0] cur_idx, chk_idx;
  logic          chk_last, chk_miss, user_ok, disp_ok;
  logic          in_solve, do_clr, do_hint, do_c, hint_act;

  function automatic logic [IW-1:0] cell_idx(input logic [RW-1:0] r, input logic [RW-1:0] c);
    return IW'(int'(r) * GRID + int'(c));
  endfunction

  assign cur_idx  = cell_idx(cur_row, cur_col);
  assign chk_idx  = cell_idx(chk_row, chk_col);
  assign chk_last = (chk_row == RW'(GRID - 1)) && (chk_col == RW'(GRID - 1));
  assign chk_miss = (puzzle[chk_idx] != solu[chk_idx]);
  assign user_ok  = (UserIn != '0) && (UserIn <= CW'(GRID));
  assign in_solve = (state == S_SOLVE);

  // Edit priority: CheckSolu > Clr > Hint > C; given cells are never written.
  assign do_clr = in_solve && !CheckSolu && Clr && !given[cur_idx];
`ifdef SINDOKU_HINT_EN
  assign hint_act = in_solve && !CheckSolu && !Clr && Hint;
`else
  assign hint_act = 1'b0;
`endif
  assign do_hint = hint_act && !given[cur_idx];
  assign do_c    = in_solve && !CheckSolu && !Clr && !hint_act && C && user_ok && !given[cur_idx];

  // Cursor wrap moves; opposite pulses together cancel.
  always_comb begin
    mv_col = cur_col;
    mv_row = cur_row;
    if (R && !L) mv_col = (cur_col == RW'(GRID - 1)) ? '0 : cur_col + 1'b1;
    if (L && !R) mv_col = (cur_col == '0) ? RW'(GRID - 1) : cur_col - 1'b1;
    if (D && !U) mv_row = (cur_row == RW'(GRID - 1)) ? '0 : cur_row + 1'b1;
    if (U && !D) mv_row = (cur_row == '0) ? RW'(GRID - 1) : cur_row - 1'b1;
  end

  // State register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= S_I;
    else          state <= state_nxt;
  end

  // Next-state logic; the final scan cycle folds in the last cell's result.
  always_comb begin
    state_nxt = state;
    case (state)
      S_I:         if (LoadStart) state_nxt = S_LOAD;
      S_LOAD:      if (LdValid && ld_idx == IW'(NC - 1)) state_nxt = S_SOLVE;
      S_SOLVE:     if (CheckSolu) state_nxt = S_CHECK;
      S_CHECK:     if (chk_last) state_nxt = (err_cnt == '0 && !chk_miss) ? S_CORRECT : S_INCORRECT;
      S_CORRECT:   if (Ack) state_nxt = S_I;
      S_INCORRECT: if (Ack) state_nxt = S_SOLVE;
      default:     state_nxt = S_I;
    endcase
  end

  // Load index, cursor, scan position and error bookkeeping.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ld_idx   <= '0;
      cur_row  <= '0;
      cur_col  <= '0;
      chk_row  <= '0;
      chk_col  <= '0;
      err_cnt  <= '0;
      ferr_row <= '0;
      ferr_col <= '0;
    end else begin
      case (state)
        S_I: if (LoadStart) ld_idx <= '0;
        S_LOAD: if (LdValid) begin
          ld_idx <= ld_idx + 1'b1;
          if (ld_idx == IW'(NC - 1)) begin
            cur_row <= '0;
            cur_col <= '0;
          end
        end
        S_SOLVE: if (CheckSolu) begin
          chk_row  <= '0;
          chk_col  <= '0;
          err_cnt  <= '0;
          ferr_row <= '0;
          ferr_col <= '0;
        end else begin
          cur_row <= mv_row;
          cur_col <= mv_col;
        end
        S_CHECK: begin
          if (chk_miss) begin
            err_cnt <= err_cnt + 1'b1;
            if (err_cnt == '0) begin
              ferr_row <= chk_row;
              ferr_col <= chk_col;
            end
          end
          if (chk_col == RW'(GRID - 1)) begin
            chk_col <= '0;
            chk_row <= chk_row + 1'b1;
          end else begin
            chk_col <= chk_col + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Board storage: load beats and player edits.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NC; i++) begin
        puzzle[i] <= '0;
        solu[i]   <= '0;
      end
      given <= '0;
    end else if (state == S_LOAD && LdValid) begin
      puzzle[ld_idx] <= LdGiven;
      solu[ld_idx]   <= LdSolu;
      given[ld_idx]  <= (LdGiven != '0);
    end else if (do_clr) begin
      puzzle[cur_idx] <= '0;
    end else if (do_hint) begin
      puzzle[cur_idx] <= solu[cur_idx];
    end else if (do_c) begin
      puzzle[cur_idx] <= UserIn;
    end
  end

`ifdef SINDOKU_HINT_EN
  logic [3:0] hint_cnt;
  // Hint usage counter, saturating.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)                           hint_cnt <= '0;
    else if (hint_act && hint_cnt != 4'hf) hint_cnt <= hint_cnt + 1'b1;
  end
  assign HintCount = hint_cnt;
`endif

  assign disp_ok   = (int'(DispRow) < GRID) && (int'(DispCol) < GRID);
  assign DispVal   = disp_ok ? puzzle[cell_idx(DispRow, DispCol)] : '0;
  assign DispGiven = disp_ok ? given[cell_idx(DispRow, DispCol)] : 1'b0;

  assign CurRow      = cur_row;
  assign CurCol      = cur_col;
  assign ErrCount    = err_cnt;
  assign FirstErrRow = ferr_row;
  assign FirstErrCol = ferr_col;

  assign q_I         = (state == S_I);
  assign q_Load      = (state == S_LOAD);
  assign q_Solve     = (state == S_SOLVE);
  assign q_Check     = (state == S_CHECK);
  assign q_Correct   = (state == S_CORRECT);
  assign q_Incorrect = (state == S_INCORRECT);

endmodule
